anton_neopixel_stream_sequencer: RTL and testbench

- Next-generation timing and addressing sequencer for the NeoPixel streamer, clocked at 6.4 MHz.
- Generalises the fixed 3-channel GRB stream in three ways:
  - CHANNELS (3 = RGB, 4 = RGBW);
  - runtime channel-order map;
  - packed or 32-bit-aligned buffer addressing.
- Adds one-shot vs loop frame modes with a HALT state and a frame-done pulse.
- Sits between the APB register file and the bit-pattern encoder; drives the buffer read address and the encoder indices.

---
 rtl/anton_neopixel_pkg.sv | 22 ++
 rtl/anton_neopixel_addr_map.sv | 37 +++
 rtl/anton_neopixel_stream_sequencer.sv | 141 ++++++++++++++
 tb/tb_anton_neopixel_stream_sequencer.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/anton_neopixel_pkg.sv
// rtl/anton_neopixel_pkg.sv - shared state encoding, defaults and helpers for the NeoPixel sequencer
package anton_neopixel_pkg;

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_TRANSMIT = 2'd1;
    localparam logic [1:0] ST_LATCH    = 2'd2;
    localparam logic [1:0] ST_HALT     = 2'd3;

    localparam int CHANNELS_DEFAULT    = 3;
    localparam int PATTERN_LEN_DEFAULT = 8;
    // 50 us latch gap at 6.4 MHz
    localparam int RESET_DELAY_DEFAULT = 320;

    function automatic int CLOG2(input int value);
        int result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/anton_neopixel_addr_map.sv
// rtl/anton_neopixel_addr_map.sv - wire-order remap and buffer byte-address generation
module anton_neopixel_addr_map
    import anton_neopixel_pkg::*;
#(
    parameter int CHANNELS  = CHANNELS_DEFAULT,
    parameter int ADDR_BITS = 8
) (
    input  logic [ADDR_BITS-1:0] pixelIx,
    input  logic [1:0]           channelIx,
    input  logic [7:0]           regOrder,
    input  logic                 regCtrl32bit,
    output logic [ADDR_BITS-1:0] bufAddr
);

    localparam logic [1:0]           MC_MAX = 2'(CHANNELS - 1);
    localparam logic [ADDR_BITS-1:0] CH_MUL = ADDR_BITS'(CHANNELS);

    logic [1:0] mc;
    logic [1:0] mcPacked;

    always_comb begin
        mc = regOrder[1:0];
        case (channelIx)
            2'd0:    mc = regOrder[1:0];
            2'd1:    mc = regOrder[3:2];
            2'd2:    mc = regOrder[5:4];
            default: mc = regOrder[7:6];
        endcase
    end

    // A packed pixel has no byte beyond CHANNELS-1, so out-of-range slots read the last channel
    assign mcPacked = (mc > MC_MAX) ? MC_MAX : mc;

    assign bufAddr = regCtrl32bit ? {pixelIx[ADDR_BITS-3:0], mc}
                                  : pixelIx * CH_MUL + ADDR_BITS'(mcPacked);

endmodule

// File: rtl/anton_neopixel_stream_sequencer.sv
// rtl/anton_neopixel_stream_sequencer.sv - frame FSM and bit/channel/pixel counter chain
module anton_neopixel_stream_sequencer
    import anton_neopixel_pkg::*;
#(
    parameter int CHANNELS    = CHANNELS_DEFAULT,
    parameter int PIXELS_MAX  = 64,
    parameter int ADDR_BITS   = CLOG2(PIXELS_MAX * 4),
    parameter int PATTERN_LEN = PATTERN_LEN_DEFAULT,
    parameter int RESET_DELAY = RESET_DELAY_DEFAULT
) (
    input  logic                 clk6_4mhz,
    input  logic                 rstn,
    input  logic                 regCtrlInit,
    input  logic                 regCtrlRun,
    input  logic                 regCtrlLoop,
    input  logic                 regCtrlLimit,
    input  logic                 regCtrl32bit,
    input  logic [12:0]          regMax,
    input  logic [7:0]           regOrder,
    input  logic                 initSlow,
    output logic                 initSlowDone,
    output logic [3:0]           bitPatternIx,
    output logic [2:0]           pixelBitIx,
    output logic [1:0]           channelIx,
    output logic [ADDR_BITS-1:0] pixelIx,
    output logic [ADDR_BITS-1:0] bufAddr,
    output logic [1:0]           state,
    output logic                 streamOutput,
    output logic                 streamReset,
    output logic                 streamBitOf,
    output logic                 streamPixelOf,
    output logic                 frameDone
);

    localparam int                    LATCH_BITS = CLOG2(RESET_DELAY + 1);
    localparam logic [3:0]            PAT_LAST   = 4'(PATTERN_LEN - 1);
    localparam logic [1:0]            CH_LAST    = 2'(CHANNELS - 1);
    localparam logic [12:0]           PIX_LAST   = 13'(PIXELS_MAX - 1);
    localparam logic [LATCH_BITS-1:0] LATCH_LAST = LATCH_BITS'(RESET_DELAY - 1);

    logic [LATCH_BITS-1:0] latchCnt;
    logic                  initSlowPend;
    logic                  stopReq;
    logic                  patWrap;
    logic                  bitWrap;
    logic                  chWrap;
    logic                  isLast;
    logic                  latchEnd;
    logic [12:0]           lastIx;
    logic [12:0]           pixelIxWide;

    assign stopReq     = regCtrlInit || !regCtrlRun;
    assign lastIx      = !regCtrlLimit ? PIX_LAST : ((regMax < PIX_LAST) ? regMax : PIX_LAST);
    assign pixelIxWide = 13'(pixelIx);
    // >= rather than == so a regMax lowered below the current pixel still ends the frame
    assign isLast      = pixelIxWide >= lastIx;

    assign patWrap  = (state == ST_TRANSMIT) && (bitPatternIx == PAT_LAST);
    assign bitWrap  = patWrap && (pixelBitIx == 3'd0);
    assign chWrap   = bitWrap && (channelIx == CH_LAST);
    assign latchEnd = (state == ST_LATCH) && (latchCnt == LATCH_LAST);

    assign streamOutput  = state == ST_TRANSMIT;
    assign streamReset   = state == ST_LATCH;
    assign streamBitOf   = patWrap;
    assign streamPixelOf = chWrap && isLast;
    assign frameDone     = latchEnd && !stopReq;

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            state    <= ST_IDLE;
            latchCnt <= '0;
        end else if (stopReq) begin
            state    <= ST_IDLE;
            latchCnt <= '0;
        end else begin
            case (state)
                ST_IDLE: state <= ST_TRANSMIT;
                ST_TRANSMIT: begin
                    if (streamPixelOf) state <= ST_LATCH;
                end
                ST_LATCH: begin
                    if (latchEnd) begin
                        state    <= regCtrlLoop ? ST_TRANSMIT : ST_HALT;
                        latchCnt <= '0;
                    end else begin
                        latchCnt <= latchCnt + LATCH_BITS'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            bitPatternIx <= '0;
            pixelBitIx   <= '0;
            channelIx    <= '0;
            pixelIx      <= '0;
        end else if (stopReq || initSlow) begin
            bitPatternIx <= '0;
            pixelBitIx   <= '0;
            channelIx    <= '0;
            pixelIx      <= '0;
        end else if (state == ST_IDLE) begin
            // Leaving IDLE: the first data bit on the wire is the MSB
            bitPatternIx <= '0;
            pixelBitIx   <= 3'd7;
            channelIx    <= '0;
            pixelIx      <= '0;
        end else if (state == ST_TRANSMIT) begin
            bitPatternIx <= patWrap ? 4'd0 : bitPatternIx + 4'd1;
            if (patWrap) pixelBitIx <= pixelBitIx - 3'd1;
            if (bitWrap) channelIx <= chWrap ? 2'd0 : channelIx + 2'd1;
            if (chWrap) pixelIx <= isLast ? '0 : pixelIx + ADDR_BITS'(1);
        end
    end

    always_ff @(posedge clk6_4mhz or negedge rstn) begin
        if (!rstn) begin
            initSlowPend <= 1'b0;
            initSlowDone <= 1'b0;
        end else begin
            initSlowPend <= initSlow;
            initSlowDone <= initSlowPend;
        end
    end

    anton_neopixel_addr_map #(
        .CHANNELS  (CHANNELS),
        .ADDR_BITS (ADDR_BITS)
    ) u_addr_map (
        .pixelIx      (pixelIx),
        .channelIx    (channelIx),
        .regOrder     (regOrder),
        .regCtrl32bit (regCtrl32bit),
        .bufAddr      (bufAddr)
    );

endmodule

// File: tb/tb_anton_neopixel_stream_sequencer.sv
// tb/tb_anton_neopixel_stream_sequencer.sv - self-checking bench for the NeoPixel stream sequencer
`timescale 1ns/1ps
module tb_anton_neopixel_stream_sequencer;
    import anton_neopixel_pkg::*;

    localparam int PL = 8;
    localparam int RD = 16;
    localparam int AB = 8;

    logic        clk6_4mhz = 1'b0;
    logic        rstn;
    logic        regCtrlInit, regCtrlRun, regCtrlLoop, regCtrlLimit, regCtrl32bit;
    logic [12:0] regMax;
    logic [7:0]  regOrder;
    logic        initSlow;

    logic          done3, done4, out3, out4, rs3, rs4, bof3, bof4, pof3, pof4, fd3, fd4;
    logic [3:0]    pat3, pat4;
    logic [2:0]    bit3, bit4;
    logic [1:0]    ch3, ch4, st3, st4;
    logic [AB-1:0] pix3, pix4, addr3, addr4;

    bit            useFour;
    logic          curDone, curOut, curRs, curBof, curPof, curFd;
    logic [3:0]    curPat;
    logic [2:0]    curBit;
    logic [1:0]    curCh, curState;
    logic [AB-1:0] curPix, curAddr;

    int checks = 0;
    int errors = 0;

    anton_neopixel_stream_sequencer #(.CHANNELS(3), .PIXELS_MAX(64), .PATTERN_LEN(PL), .RESET_DELAY(RD)) dut3 (
        .clk6_4mhz(clk6_4mhz), .rstn(rstn), .regCtrlInit(regCtrlInit), .regCtrlRun(regCtrlRun),
        .regCtrlLoop(regCtrlLoop), .regCtrlLimit(regCtrlLimit), .regCtrl32bit(regCtrl32bit),
        .regMax(regMax), .regOrder(regOrder), .initSlow(initSlow), .initSlowDone(done3),
        .bitPatternIx(pat3), .pixelBitIx(bit3), .channelIx(ch3), .pixelIx(pix3), .bufAddr(addr3),
        .state(st3), .streamOutput(out3), .streamReset(rs3), .streamBitOf(bof3),
        .streamPixelOf(pof3), .frameDone(fd3)
    );

    anton_neopixel_stream_sequencer #(.CHANNELS(4), .PIXELS_MAX(64), .PATTERN_LEN(PL), .RESET_DELAY(RD)) dut4 (
        .clk6_4mhz(clk6_4mhz), .rstn(rstn), .regCtrlInit(regCtrlInit), .regCtrlRun(regCtrlRun),
        .regCtrlLoop(regCtrlLoop), .regCtrlLimit(regCtrlLimit), .regCtrl32bit(regCtrl32bit),
        .regMax(regMax), .regOrder(regOrder), .initSlow(initSlow), .initSlowDone(done4),
        .bitPatternIx(pat4), .pixelBitIx(bit4), .channelIx(ch4), .pixelIx(pix4), .bufAddr(addr4),
        .state(st4), .streamOutput(out4), .streamReset(rs4), .streamBitOf(bof4),
        .streamPixelOf(pof4), .frameDone(fd4)
    );

    assign curDone  = useFour ? done4 : done3;
    assign curOut   = useFour ? out4  : out3;
    assign curRs    = useFour ? rs4   : rs3;
    assign curBof   = useFour ? bof4  : bof3;
    assign curPof   = useFour ? pof4  : pof3;
    assign curFd    = useFour ? fd4   : fd3;
    assign curPat   = useFour ? pat4  : pat3;
    assign curBit   = useFour ? bit4  : bit3;
    assign curCh    = useFour ? ch4   : ch3;
    assign curState = useFour ? st4   : st3;
    assign curPix   = useFour ? pix4  : pix3;
    assign curAddr  = useFour ? addr4 : addr3;

    always #78 clk6_4mhz = ~clk6_4mhz;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk6_4mhz);
        #1;
    endtask

    function automatic int pack(int st, int pat, int bt, int ch, int pix, int addr, int bof, int pof, int out);
        return (st << 28) | (pat << 24) | (bt << 21) | (ch << 19) | (pix << 11) | (addr << 3) | (bof << 2) | (pof << 1) | out;
    endfunction

    function automatic int curPack();
        return pack(int'(curState), int'(curPat), int'(curBit), int'(curCh), int'(curPix), int'(curAddr),
                    int'(curBof), int'(curPof), int'(curOut));
    endfunction

    // Byte address of the k-th TRANSMIT cycle of a frame, straight from the pixel/slot arithmetic
    function automatic int modelAddr(int k, int nch, bit b32, logic [7:0] ord);
        int pix, slot, mc;
        pix  = k / (nch * 8 * PL);
        slot = (k / (8 * PL)) % nch;
        mc   = (int'(ord) >> (2 * slot)) & 3;
        if (b32) return (pix * 4 + mc) % 256;
        if (mc > nch - 1) mc = nch - 1;
        return (pix * nch + mc) % 256;
    endfunction

    task automatic startFrame(input bit four, input bit lim, input int mx, input bit b32,
                              input logic [7:0] ord, input bit lp);
        useFour      = four;
        regCtrlInit  = 1'b1;
        regCtrlRun   = 1'b1;
        regCtrlLimit = lim;
        regMax       = 13'(mx);
        regCtrl32bit = b32;
        regOrder     = ord;
        regCtrlLoop  = lp;
        initSlow     = 1'b0;
        step();
        regCtrlInit = 1'b0;
        step();
    endtask

    task automatic runFrame(input bit four, input bit lim, input int mx, input bit b32, input logic [7:0] ord);
        int nch, last, n, expPack;
        nch  = four ? 4 : 3;
        last = lim ? ((mx < 63) ? mx : 63) : 63;
        n    = (last + 1) * nch * 8 * PL;
        startFrame(four, lim, mx, b32, ord, 1'b0);
        for (int k = 0; k < n; k++) begin
            expPack = pack(1, k % PL, 7 - (k / PL) % 8, (k / (8 * PL)) % nch, k / (nch * 8 * PL),
                           modelAddr(k, nch, b32, ord), int'(k % PL == PL - 1), int'(k == n - 1), 1);
            check($sformatf("frame c%0d k%0d", nch, k), curPack(), expPack);
            step();
        end
        for (int j = 0; j < RD; j++) begin
            check($sformatf("latch j%0d", j), {curState, curRs, curFd, curOut}, {ST_LATCH, 1'b1, j == RD - 1, 1'b0});
            step();
        end
        check("halt state", {curState, curFd, curOut, curRs}, {ST_HALT, 3'b000});
        regCtrlRun = 1'b0;
        step();
        check("halt to idle", curPack(), pack(0, 0, 0, 0, 0, modelAddr(0, nch, b32, ord), 0, 0, 0));
    endtask

    typedef struct {
        bit              four;
        bit              b32;
        logic [7:0]      ord;
        int              pixel;
        logic [3:0][7:0] exp;
    } addr_vec_t;

    addr_vec_t vecs[5];

    initial begin
        int nch, fdCount, pofCount;

        vecs[0] = '{1'b1, 1'b0, 8'b11_10_00_01, 2, 32'h0B0A0809};
        vecs[1] = '{1'b0, 1'b1, 8'b00_10_00_01, 5, 32'h00161415};
        vecs[2] = '{1'b0, 1'b0, 8'b00_10_01_00, 4, 32'h000E0D0C};
        vecs[3] = '{1'b0, 1'b0, 8'b00_00_11_10, 1, 32'h00030505};
        vecs[4] = '{1'b1, 1'b1, 8'b00_01_10_11, 7, 32'h1C1D1E1F};

        rstn = 1'b0;
        useFour = 1'b0;
        regCtrlInit = 1'b0; regCtrlRun = 1'b1; regCtrlLoop = 1'b0; regCtrlLimit = 1'b0;
        regCtrl32bit = 1'b0; regMax = '0; regOrder = '0; initSlow = 1'b0;
        repeat (3) step();
        check("reset dut3", pack(int'(st3), int'(pat3), int'(bit3), int'(ch3), int'(pix3), int'(addr3),
                                 int'(bof3), int'(pof3), int'(out3)), 0);
        check("reset dut4", pack(int'(st4), int'(pat4), int'(bit4), int'(ch4), int'(pix4), int'(addr4),
                                 int'(bof4), int'(pof4), int'(out4)), 0);
        check("reset pulses", {done3, done4, fd3, fd4, rs3, rs4}, 0);
        rstn = 1'b1;
        step();

        runFrame(1'b0, 1'b1, 1, 1'b0, 8'b00_10_01_00);

        for (int v = 0; v < 5; v++) begin
            nch = vecs[v].four ? 4 : 3;
            startFrame(vecs[v].four, 1'b0, 0, vecs[v].b32, vecs[v].ord, 1'b0);
            for (int i = 0; i < 20000 && curPix != AB'(vecs[v].pixel); i++) step();
            check($sformatf("vec%0d reach pixel", v), int'(curPix), vecs[v].pixel);
            for (int s = 0; s < nch; s++) begin
                check($sformatf("vec%0d slot%0d ch", v, s), int'(curCh), s);
                check($sformatf("vec%0d slot%0d addr", v, s), int'(curAddr), int'(vecs[v].exp[s]));
                repeat (8 * PL) step();
            end
            check($sformatf("vec%0d next pixel", v), int'(curPix), vecs[v].pixel + 1);
        end

        for (int r = 0; r < 8; r++) begin
            runFrame(1'($urandom_range(0, 1)), 1'b1, $urandom_range(0, 3), 1'($urandom_range(0, 1)), 8'($urandom));
        end
        runFrame(1'b0, 1'b1, 8191, 1'b1, 8'($urandom));

        startFrame(1'b0, 1'b1, 0, 1'b0, 8'b00_10_01_00, 1'b1);
        fdCount = 0;
        pofCount = 0;
        for (int i = 0; i < 3 * (3 * 8 * PL + RD); i++) begin
            if (curFd) fdCount++;
            if (curPof) pofCount++;
            step();
        end
        check("loop frameDone count", fdCount, 3);
        check("loop pixelOf count", pofCount, 3);
        check("loop restart", {curState, curPix, curBit, curPat}, {ST_TRANSMIT, 8'd0, 3'd7, 4'd0});
        for (int i = 0; i < 300 && curState != ST_LATCH; i++) step();
        check("loop reach latch", int'(curState), int'(ST_LATCH));
        repeat (5) step();
        regCtrlRun = 1'b0;
        step();
        check("run drop in latch", {curState, curRs, curFd, curBit}, {ST_IDLE, 5'd0});

        startFrame(1'b0, 1'b0, 0, 1'b0, 8'b00_10_01_00, 1'b0);
        for (int i = 0; i < 1000 && curPix != 8'd3; i++) step();
        repeat (70) step();
        check("initSlow at pixel 3", {curPix, curCh}, {8'd3, 2'd1});
        initSlow = 1'b1;
        step();
        initSlow = 1'b0;
        check("initSlow clear", {curPat, curBit, curCh, curPix, curDone}, 0);
        check("initSlow keeps state", int'(curState), int'(ST_TRANSMIT));
        step();
        check("initSlowDone high", int'(curDone), 1);
        step();
        check("initSlowDone low", int'(curDone), 0);

        for (int i = 0; i < 2000 && !(curPix == 8'd2 && curCh == 2'd2 && curBit == 3'd0 && curPat == 4'd7); i++) step();
        check("reach channel wrap", {curPix, curCh, curBit, curPat}, {8'd2, 2'd2, 3'd0, 4'd7});
        initSlow = 1'b1;
        step();
        initSlow = 1'b0;
        check("initSlow beats overflow", {curPat, curBit, curCh, curPix}, 0);
        repeat (2) step();
        regCtrlRun = 1'b0;
        step();

        startFrame(1'b0, 1'b1, 5, 1'b0, 8'b00_10_01_00, 1'b0);
        for (int i = 0; i < 1000 && curPix != 8'd3; i++) step();
        regMax = 13'd1;
        for (int i = 0; i < 300 && !curPof; i++) step();
        check("lowered regMax end pixel", {curPof, curPix, curCh}, {1'b1, 8'd3, 2'd2});
        step();
        check("lowered regMax latch", int'(curState), int'(ST_LATCH));
        regCtrlRun = 1'b0;
        step();

        startFrame(1'b1, 1'b0, 0, 1'b0, 8'b11_10_01_10, 1'b0);
        repeat (500) step();
        check("pre-reset transmit", int'(curState), int'(ST_TRANSMIT));
        #40;
        rstn = 1'b0;
        #1;
        check("async reset outputs", curPack(), pack(0, 0, 0, 0, 0, modelAddr(0, 4, 1'b0, regOrder), 0, 0, 0));
        check("async reset pulses", {curFd, curDone, curRs}, 0);
        #20;
        rstn = 1'b1;
        step();
        check("restart after reset", curPack(), pack(1, 0, 7, 0, 0, 2, 0, 0, 1));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
